// File: rtl/rv_pkg.sv
// Shared definitions for the RV32M divide unit: op encodings, FSM states and
// the RISC-V special-case result values.
package rv_pkg;

   localparam int DIV_XLEN = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_CALC = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } div_state_e;

   // Wide enough for any supported XLEN; users slice to their width.
   localparam logic [63:0] DIV_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [63:0] div_signed_min(input int unsigned width);
      return 64'd1 << (width - 32'd1);
   endfunction

endpackage

// File: rtl/rv_div_unit_if.sv
// Start/done handshake between the core pipeline (master) and the divider (slave).
interface rv_div_unit_if #(parameter int XLEN = 32);

   logic            start;
   logic [1:0]      div_op;
   logic [XLEN-1:0] A_in;
   logic [XLEN-1:0] B_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, div_op, A_in, B_in,
                   input  busy, done, result);

   modport slave  (input  start, div_op, A_in, B_in,
                   output busy, done, result);

endinterface

// File: rtl/rv_div_core.sv
// Unsigned radix-2 restoring divider datapath: one shift/trial-subtract step per
// enabled cycle, with an iteration counter flagging the last step.
module rv_div_core
   import rv_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_step,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_quo,
   output logic [XLEN-1:0] o_rem,
   output logic            o_last
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_dvs;
   logic [CW-1:0]   r_cnt;

   logic [XLEN:0]   w_rem_sh;
   logic [XLEN:0]   w_diff;

   // The partial remainder stays below the divisor, so an XLEN+1-bit difference
   // has its top bit set exactly when the trial subtraction goes negative.
   assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};

   assign o_quo  = r_quo;
   assign o_rem  = r_rem;
   assign o_last = (r_cnt == CW'(XLEN - 1));

   // Datapath registers: load on PREP, one restoring step per CALC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem <= {XLEN{1'b0}};
         r_quo <= {XLEN{1'b0}};
         r_dvs <= {XLEN{1'b0}};
         r_cnt <= {CW{1'b0}};
      end else if (i_load) begin
         r_rem <= {XLEN{1'b0}};
         r_quo <= i_dividend;
         r_dvs <= i_divisor;
         r_cnt <= {CW{1'b0}};
      end else if (i_step) begin
         if (!w_diff[XLEN]) begin
            r_rem <= w_diff[XLEN-1:0];
         end else begin
            r_rem <= w_rem_sh[XLEN-1:0];
         end
         r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/rv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: FSM, sign handling, special cases and the
// registered result around the unsigned iterative core.
module rv_div_unit
   import rv_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
)
(
   input  logic         clk,
   input  logic         rst_n,
   rv_div_unit_if.slave bus
);

   localparam logic [XLEN-1:0] ALL_ONES = DIV_ALL_ONES[XLEN-1:0];
   localparam logic [XLEN-1:0] SMIN     = XLEN'(div_signed_min(XLEN));

   function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   div_state_e      r_state;
   logic [1:0]      r_op;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_result;
   logic            r_busy;
   logic            r_done;

   logic            w_signed;
   logic            w_sel_rem;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_div0;
   logic            w_ovf;
   logic            w_load;
   logic            w_step;
   logic [XLEN-1:0] w_quo;
   logic [XLEN-1:0] w_rem;
   logic            w_last;
   logic [XLEN-1:0] w_quo_fix;
   logic [XLEN-1:0] w_rem_fix;

   assign w_signed  = (r_op == OP_DIV) || (r_op == OP_REM);
   assign w_sel_rem = (r_op == OP_REM) || (r_op == OP_REMU);
   assign w_a_neg   = w_signed & r_a[XLEN-1];
   assign w_b_neg   = w_signed & r_b[XLEN-1];
   assign w_a_mag   = w_a_neg ? f_neg(r_a) : r_a;
   assign w_b_mag   = w_b_neg ? f_neg(r_b) : r_b;
   assign w_div0    = (r_b == {XLEN{1'b0}});
   assign w_ovf     = w_signed && (r_a == SMIN) && (r_b == ALL_ONES);
   assign w_load    = (r_state == ST_PREP) && !w_div0 && !w_ovf;
   assign w_step    = (r_state == ST_CALC);

   // Sign flags are zero for unsigned ops, so FIX passes those through untouched.
   assign w_quo_fix = (w_a_neg ^ w_b_neg) ? f_neg(w_quo) : w_quo;
   assign w_rem_fix = w_a_neg ? f_neg(w_rem) : w_rem;

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;

   rv_div_core #(.XLEN(XLEN)) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_step     (w_step),
      .i_dividend (w_a_mag),
      .i_divisor  (w_b_mag),
      .o_quo      (w_quo),
      .o_rem      (w_rem),
      .o_last     (w_last)
   );

   // Control FSM with registered busy/done/result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_op     <= 2'b00;
         r_a      <= {XLEN{1'b0}};
         r_b      <= {XLEN{1'b0}};
         r_result <= {XLEN{1'b0}};
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.A_in;
                  r_b     <= bus.B_in;
                  r_op    <= bus.div_op;
                  r_busy  <= 1'b1;
                  r_state <= ST_PREP;
               end
            end
            ST_PREP: begin
               if (w_div0) begin
                  r_result <= w_sel_rem ? r_a : ALL_ONES;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end else if (w_ovf) begin
                  r_result <= w_sel_rem ? {XLEN{1'b0}} : SMIN;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end else begin
                  r_state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (w_last) begin
                  r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               r_result <= w_sel_rem ? w_rem_fix : w_quo_fix;
               r_done   <= 1'b1;
               r_state  <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_div_unit.sv
// Directed plus randomized bench for rv_div_unit, checked against an
// arithmetic reference model of the RISC-V divide rules.
module tb_rv_div_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rv_div_unit_if #(.XLEN(32)) bus ();

   rv_div_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_model(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'h0000_0000 : 32'h8000_0000;
      case (op)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return $urandom_range(0, 100);
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one operation; optionally pokes start mid-CALC and during DONE.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject, input string tag);
      logic [31:0] exp;
      bit          special;
      int          k;
      exp     = ref_model(op, a, b);
      special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      @(negedge clk);
      bus.start = 1'b1; bus.div_op = op; bus.A_in = a; bus.B_in = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.A_in = $urandom; bus.B_in = $urandom; bus.div_op = 2'($urandom);
      chk({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
      k = 0;
      while (bus.done !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
         if (inject && k == 5) begin
            bus.start = 1'b1; bus.A_in = $urandom; bus.B_in = $urandom;
            bus.div_op = 2'($urandom);
         end else begin
            bus.start = 1'b0;
         end
      end
      chk({tag, "_latency"}, k, special ? 32'd1 : 32'd34);
      chk({tag, "_result"}, bus.result, exp);
      if (inject) begin
         bus.start = 1'b1; bus.A_in = $urandom; bus.B_in = $urandom;
      end
      @(negedge clk);
      chk({tag, "_done_fall"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_busy_fall"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_hold"}, bus.result, exp);
      bus.start = 1'b0;
   endtask

   initial begin
      logic [1:0]  d_op [11];
      logic [31:0] d_a  [11];
      logic [31:0] d_b  [11];
      int          n_done;

      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.div_op = 2'b00; bus.A_in = 32'd0; bus.B_in = 32'd0;

      d_op = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b11};
      d_a  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd1234, 32'd1234,
               32'd1234, 32'h8000_0000, 32'h8000_0000, 32'd1234};
      d_b  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
               32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_result", bus.result, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) do_op(d_op[i], d_a[i], d_b[i], 1'b0, $sformatf("dir%0d", i));

      do_op(2'b01, 32'd1000, 32'd3, 1'b1, "inject");
      do_op(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0, "after_inject");

      for (int i = 0; i < 30; i++)
         do_op(2'($urandom), pick(), pick(), ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));

      // Abort a DIVU at T+10 and make sure it never completes.
      @(negedge clk);
      bus.start = 1'b1; bus.div_op = 2'b01; bus.A_in = 32'd5000; bus.B_in = 32'd3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_result", bus.result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) n_done++;
      end
      chk("abort_no_done", n_done, 32'd0);
      chk("abort_idle_busy", {31'd0, bus.busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_div_unit.md
# rv_div_unit

Iterative RV32M divide/remainder unit executing DIV, DIVU, REM and REMU with a start/done handshake. It is the multi-cycle companion to the single-cycle integer ALU. The core stalls on `busy` and takes `result` on the `done` pulse, using the same funct3-derived op-code style as the ALU. Division is radix-2 restoring on magnitudes, with a one-cycle sign-correction step and RISC-V-defined special-case results.

## Interface
- `XLEN`, default 32: operand and result width. Iteration count equals `XLEN`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request. Sampled only in IDLE.
- `div_op` input 2: funct3[1:0]. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `A_in` input XLEN: dividend, captured when `start` is accepted.
- `B_in` input XLEN: divisor, captured when `start` is accepted.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse; `result` is valid while it is high.
- `result` output XLEN: quotient or remainder. Registered and held until the next accepted `start`.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE with `start`=1: capture `A_in`, `B_in` and `div_op`, then go to PREP. `start` is ignored in every other state; there is no queueing.
- PREP: compute sign flags and magnitudes. Signed ops take |A| and |B|; unsigned ops use the operands raw. Detect the special cases:
  - Divisor zero: quotient = all ones; remainder = dividend. Go to DONE.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000; remainder = 0. Go to DONE.
  - Otherwise: clear the partial remainder, load the quotient register with |A|, set the counter to 0, go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by one.
  - Trial-subtract |B| from rem, using an XLEN+1-bit subtraction.
  - If non-negative, keep the difference and set quo[0]=1.
  - After `XLEN` steps (counter wraps from XLEN-1), go to FIX.
- FIX (signed ops only):
  - Negate the quotient when the dividend and divisor signs differ.
  - Negate the remainder when the dividend is negative.
  - Select the quotient or the remainder by `div_op[1]` and load `result`. Go to DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE unconditionally.
- Arithmetic rules: two's-complement negation by inversion plus one, truncated to XLEN. The remainder always satisfies |rem| < |B|.

## Timing
- Take T as the rising edge that samples `start`=1 in IDLE.
- Normal operation: PREP after T; CALC after T+1; the 32 iterations run on edges T+2..T+33; FIX after T+33; DONE after T+34. `done` is high between T+34 and T+35, giving a latency of 35 cycles.
- Special cases: DONE after T+1, so `done` is high between T+1 and T+2.
- `busy` rises after T and falls after the edge that leaves DONE. Back-to-back: `start` may be accepted on the edge that exits DONE+1 (first IDLE cycle).
- Reset (`rst_n`=0) at any time, including mid-CALC:
  - Immediately forces IDLE and clears `busy`, `done`, `result`, the counter and all datapath registers to 0.
  - No `done` pulse is produced for an aborted operation.
- Reset values of all outputs: `busy`=0, `done`=0, `result`=0.
- `A_in`, `B_in` and `div_op` may change freely after T without affecting the operation in flight.

## Structure
- Shared package `rv_pkg`:
  - `div_op` encodings DIV/DIVU/REM/REMU.
  - State enum (IDLE, PREP, CALC, FIX, DONE).
  - Special-result constants (all-ones, signed minimum).
- Natural sub-module `rv_div_core`: unsigned iterative shift-subtract datapath (rem/quo registers, counter, trial subtract).
- The top level `rv_div_unit` holds the FSM, sign handling, special cases and the result register.

## Test plan
- DIVU A=100, B=7 -> `result`=14, `done` between T+34 and T+35; REMU on the same operands -> 2.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM A=7, B=0xFFFFFFFE (-2) -> 1.
- Divide by zero:
  - DIV and DIVU A=1234, B=0 -> 0xFFFFFFFF.
  - REM A=1234, B=0 -> 1234.
  - In all cases `done` is high between T+1 and T+2.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; both at two-cycle latency.
- `start` pulsed with new operands during CALC and in DONE -> ignored; the first result is unchanged; the next `start` in IDLE is accepted.
- `rst_n` asserted at T+10 of a DIVU -> `busy`, `done` and `result` are 0 immediately; after release with no new `start`, no `done` pulse ever occurs.
